vote_alarm_ctrl: RTL and testbench
==================================

Name: vote_alarm_ctrl

Overview:
- Sequential stage directly downstream of the 3-input majority-vote block (P/T/H -> E).
- Qualifies the vote output E over consecutive clock cycles, then raises a latched alarm.
- Enforces a minimum alarm-on time and requires an operator acknowledge handshake.
- Counts alarm events for display logic.

Parameters:
- QUAL_CYCLES, default 4: number of consecutive cycles E must be sampled high to trigger. Legal range 1..15.
- HOLD_CYCLES, default 8: minimum cycles Alarm stays high before Ack is honoured. Legal range 1..15.
- CNT_W, default 4: width of the internal qualify and hold counters. Must hold 15.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- E  input  1  majority-vote result from the upstream vote block.
- Ack  input  1  operator acknowledge, level-sampled each edge.
- Alarm  output  1  registered alarm indicator.
- Pending  output  1  high from alarm trigger until the event is fully cleared.
- State  output  2  current FSM state encoding, for debug/LEDs.
- Count  output  8  alarm events since reset, saturating.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-high; it has priority over all other inputs.
  - Reset values: Alarm=0, Pending=0, State=00, Count=0, internal counters=0.
  - Reset asserted mid-operation returns everything to reset values at the next edge.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states: IDLE=00, QUAL=01, ALARM=10, WAIT_CLR=11.
- IDLE:
  - E=1 -> QUAL, with qual_cnt=1.
  - If QUAL_CYCLES==1, E=1 goes straight to ALARM instead.
  - Ack is ignored.
- QUAL:
  - E=1 and qual_cnt==QUAL_CYCLES-1 -> ALARM.
  - E=1 otherwise -> qual_cnt+1.
  - E=0 -> IDLE, qual_cnt=0.
  - Ack is ignored.
- Latency: if E is sampled high on edges k..k+QUAL_CYCLES-1, Alarm=1 after edge k+QUAL_CYCLES-1.
- Entering ALARM:
  - Alarm=1, Pending=1, hold_cnt=0.
  - Count+1, saturating at 255 (no wrap).
- ALARM:
  - hold_cnt increments each cycle and saturates at HOLD_CYCLES-1.
  - E dropping does not clear Alarm.
  - Ack is honoured only at an edge where hold_cnt==HOLD_CYCLES-1; it is ignored earlier and not remembered.
  - Minimum Alarm high time is exactly HOLD_CYCLES cycles.
  - Honoured Ack with E=0 -> IDLE, Alarm=0, Pending=0.
  - Honoured Ack with E=1 -> WAIT_CLR, Alarm=0, Pending stays 1.
- WAIT_CLR:
  - No retrigger while E stays high; Ack is ignored.
  - E=0 -> IDLE, Pending=0.
- Re-arming therefore always requires E to be observed low at least once.
- Simultaneous Reset and Ack/E: Reset wins.

Optional Feature:
- Macro: VOTE_ALARM_AUTOCLR_EN.
- Defined: in ALARM, once hold_cnt==HOLD_CYCLES-1 and E=0, the FSM goes to IDLE without Ack (Alarm=0, Pending=0 at that edge). Ack behaviour is otherwise unchanged.
- Undefined: Ack is mandatory to leave ALARM, exactly as in Behaviour.
- No port changes either way.

Test Plan (QUAL_CYCLES=4, HOLD_CYCLES=8, macro undefined unless stated):
- Reset high 2 cycles with E=1 and Ack=1 -> Alarm=0, Pending=0, State=00, Count=0.
- E high 3 cycles, then low -> State 00->01->01->01->00, Alarm never 1, Count=0.
- E held high from edge 1 -> after edge 4: Alarm=1, Pending=1, State=10, Count=1.
- Ack pulse on the 3rd alarm cycle -> ignored, Alarm stays 1. With E=0 and Ack on the 8th alarm cycle -> next edge Alarm=0, Pending=0, State=00.
- E still 1 at honoured Ack -> State=11, Alarm=0, Pending=1. Hold E 5 more cycles -> no retrigger. E low -> State=00. E high 4 cycles -> Alarm=1, Count=2.
- Reset asserted in ALARM -> next edge all outputs 0, Count=0. With VOTE_ALARM_AUTOCLR_EN defined, E=0 and no Ack -> Alarm clears after exactly 8 cycles.

Source files
------------

// File: rtl/vote_alarm_ctrl.sv
// vote_alarm_ctrl
//   Qualifies the majority-vote result E over consecutive cycles, then raises
//   a latched alarm. The alarm stays on for at least HOLD_CYCLES cycles and is
//   then cleared by an operator acknowledge. Alarm events are counted
//   (saturating at 255) for display logic.
//
//   Ports:
//     Clock   in   system clock, rising edge
//     Reset   in   synchronous active-high reset, priority over everything
//     E       in   majority-vote result from the upstream vote block
//     Ack     in   operator acknowledge, level-sampled each edge
//     Alarm   out  registered alarm indicator
//     Pending out  high from alarm trigger until the event is fully cleared
//     State   out  FSM state (IDLE=00, QUAL=01, ALARM=10, WAIT_CLR=11)
//     Count   out  alarm events since reset, saturating at 255
//
//   Build option: define VOTE_ALARM_AUTOCLR_EN to let ALARM return to IDLE
//   without Ack once the hold time has elapsed and E is low.
module vote_alarm_ctrl #(
  parameter int QUAL_CYCLES = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       E,
  input  logic       Ack,
  output logic       Alarm,
  output logic       Pending,
  output logic [1:0] State,
  output logic [7:0] Count
);

  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] QUAL     = 2'b01;
  localparam logic [1:0] ALARM    = 2'b10;
  localparam logic [1:0] WAIT_CLR = 2'b11;

  localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(QUAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

`ifdef VOTE_ALARM_AUTOCLR_EN
  localparam bit AUTOCLR = 1'b1;
`else
  localparam bit AUTOCLR = 1'b0;
`endif

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] qual_cnt_reg, qual_cnt_next;
  logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic             alarm_reg, alarm_next;
  logic             pending_reg, pending_next;
  logic [7:0]       count_reg, count_next;
  logic             enter_alarm;
  logic             hold_done;

  // hold_cnt saturates at HOLD_LAST, so this stays true for the rest of ALARM
  assign hold_done = (hold_cnt_reg == HOLD_LAST);

  always_comb begin
    state_next    = state_reg;
    qual_cnt_next = qual_cnt_reg;
    hold_cnt_next = hold_cnt_reg;
    alarm_next    = alarm_reg;
    pending_next  = pending_reg;
    count_next    = count_reg;
    enter_alarm   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (E) begin
          if (QUAL_CYCLES == 1) begin
            enter_alarm = 1'b1;
          end else begin
            state_next    = QUAL;
            qual_cnt_next = CNT_W'(1);
          end
        end
      end
      QUAL: begin
        if (!E) begin
          state_next    = IDLE;
          qual_cnt_next = '0;
        end else if (qual_cnt_reg == QUAL_LAST) begin
          enter_alarm = 1'b1;
        end else begin
          qual_cnt_next = qual_cnt_reg + CNT_W'(1);
        end
      end
      ALARM: begin
        if (hold_done && Ack) begin
          // E still high means the fault persists: hold off re-arming
          // until E has been seen low.
          alarm_next   = 1'b0;
          pending_next = E;
          state_next   = E ? WAIT_CLR : IDLE;
        end else if (AUTOCLR && hold_done && !E) begin
          alarm_next   = 1'b0;
          pending_next = 1'b0;
          state_next   = IDLE;
        end else if (!hold_done) begin
          hold_cnt_next = hold_cnt_reg + CNT_W'(1);
        end
      end
      WAIT_CLR: begin
        if (!E) begin
          state_next   = IDLE;
          pending_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase

    if (enter_alarm) begin
      state_next    = ALARM;
      alarm_next    = 1'b1;
      pending_next  = 1'b1;
      hold_cnt_next = '0;
      qual_cnt_next = '0;
      if (count_reg != 8'hFF) begin
        count_next = count_reg + 8'd1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg    <= IDLE;
      qual_cnt_reg <= '0;
      hold_cnt_reg <= '0;
      alarm_reg    <= 1'b0;
      pending_reg  <= 1'b0;
      count_reg    <= 8'd0;
    end else begin
      state_reg    <= state_next;
      qual_cnt_reg <= qual_cnt_next;
      hold_cnt_reg <= hold_cnt_next;
      alarm_reg    <= alarm_next;
      pending_reg  <= pending_next;
      count_reg    <= count_next;
    end
  end

  assign Alarm   = alarm_reg;
  assign Pending = pending_reg;
  assign State   = state_reg;
  assign Count   = count_reg;

endmodule

// File: tb/tb_vote_alarm_ctrl.sv
// Testbench for vote_alarm_ctrl (QUAL_CYCLES=4, HOLD_CYCLES=8).
// A table of per-edge vectors covers the main flow; hand-written sequences
// cover reset inside ALARM, the auto-clear option and count saturation.
module tb_vote_alarm_ctrl;

  logic       clk;
  logic       rst;
  logic       e;
  logic       ack;
  logic       alarm;
  logic       pending;
  logic [1:0] state;
  logic [7:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  vote_alarm_ctrl #(
    .QUAL_CYCLES(4),
    .HOLD_CYCLES(8),
    .CNT_W(4)
  ) dut (
    .Clock  (clk),
    .Reset  (rst),
    .E      (e),
    .Ack    (ack),
    .Alarm  (alarm),
    .Pending(pending),
    .State  (state),
    .Count  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       e;
    logic       ack;
    logic       alarm;
    logic       pending;
    logic [1:0] st;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic ei, input logic a,
                     input logic al, input logic pd, input logic [1:0] st,
                     input logic [7:0] cnt);
    vec_t v;
    v.rst = r; v.e = ei; v.ack = a;
    v.alarm = al; v.pending = pd; v.st = st; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // drive inputs, clock one edge, sample 1 ns later
  task automatic step(input logic r, input logic ei, input logic a);
    rst = r; e = ei; ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic al, input logic pd,
                           input logic [1:0] st, input logic [7:0] cnt);
    check({tag, ".alarm"},   int'(alarm),   int'(al));
    check({tag, ".pending"}, int'(pending), int'(pd));
    check({tag, ".state"},   int'(state),   int'(st));
    check({tag, ".count"},   int'(count),   int'(cnt));
  endtask

  int exp_cnt;

  initial begin
    rst = 1'b1; e = 1'b1; ack = 1'b1;

    // reset with E and Ack high
    add(1,1,1, 0,0,2'b00,0);
    add(1,1,1, 0,0,2'b00,0);
    // E high 3 cycles then low: no alarm
    add(0,1,0, 0,0,2'b01,0);
    add(0,1,0, 0,0,2'b01,0);
    add(0,1,0, 0,0,2'b01,0);
    add(0,0,0, 0,0,2'b00,0);
    // qualify 4 edges (Ack ignored in QUAL), alarm on 4th
    add(0,1,1, 0,0,2'b01,0);
    add(0,1,0, 0,0,2'b01,0);
    add(0,1,0, 0,0,2'b01,0);
    add(0,1,0, 1,1,2'b10,1);
    // hold: early Ack ignored, E dropping does not clear
    add(0,1,0, 1,1,2'b10,1);
    add(0,0,0, 1,1,2'b10,1);
    add(0,0,1, 1,1,2'b10,1);
    add(0,0,0, 1,1,2'b10,1);
    add(0,0,0, 1,1,2'b10,1);
    add(0,0,0, 1,1,2'b10,1);
    add(0,0,0, 1,1,2'b10,1);
    // 8th alarm cycle: Ack with E=0 -> IDLE
    add(0,0,1, 0,0,2'b00,1);
    // retrigger
    add(0,1,0, 0,0,2'b01,1);
    add(0,1,0, 0,0,2'b01,1);
    add(0,1,0, 0,0,2'b01,1);
    add(0,1,0, 1,1,2'b10,2);
    for (int i = 0; i < 6; i++) add(0,1,0, 1,1,2'b10,2);
    // Ack one edge too early (hold_cnt=6): ignored
    add(0,1,1, 1,1,2'b10,2);
    // honoured Ack with E=1 -> WAIT_CLR
    add(0,1,1, 0,1,2'b11,2);
    // E held 5 more cycles, Ack toggling: no retrigger
    for (int i = 0; i < 5; i++) add(0,1,i[0], 0,1,2'b11,2);
    add(0,0,0, 0,0,2'b00,2);
    // rearm
    add(0,1,0, 0,0,2'b01,2);
    add(0,1,0, 0,0,2'b01,2);
    add(0,1,0, 0,0,2'b01,2);
    add(0,1,0, 1,1,2'b10,3);
    add(0,1,0, 1,1,2'b10,3);
    // reset in ALARM, with E and Ack high
    add(1,1,1, 0,0,2'b00,0);
    add(0,0,0, 0,0,2'b00,0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].e, vecs[i].ack);
      $display("vec %0d rst=%0d e=%0d ack=%0d -> alarm=%0d pending=%0d state=%0d count=%0d",
               i, rst, e, ack, alarm, pending, state, count);
      check_all($sformatf("vec%0d", i), vecs[i].alarm, vecs[i].pending,
                vecs[i].st, vecs[i].cnt);
    end

    // alarm with E=0 and no Ack after the hold time
    for (int i = 0; i < 3; i++) step(0,1,0);
    step(0,1,0);
    check_all("autoclr_entry", 1, 1, 2'b10, 1);
    for (int i = 1; i < 8; i++) begin
      step(0,0,0);
      check($sformatf("autoclr_hold%0d", i), int'(alarm), 1);
    end
    step(0,0,0);
`ifdef VOTE_ALARM_AUTOCLR_EN
    $display("autoclr: after 8 cycles alarm=%0d state=%0d", alarm, state);
    check_all("autoclr_clear", 0, 0, 2'b00, 1);
`else
    for (int i = 0; i < 10; i++) step(0,0,0);
    $display("no autoclr: after 18 cycles alarm=%0d state=%0d", alarm, state);
    check_all("ack_required", 1, 1, 2'b10, 1);
    step(0,0,1);
    check_all("ack_clear", 0, 0, 2'b00, 1);
`endif

    // count saturation at 255
    exp_cnt = 1;
    for (int n = 0; n < 258; n++) begin
      for (int i = 0; i < 4; i++) step(0,1,0);
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      check($sformatf("sat_count%0d", n), int'(count), exp_cnt);
      for (int i = 0; i < 8; i++) step(0,0,1);
      check($sformatf("sat_state%0d", n), int'(state), 0);
      if (n >= 252)
        $display("event %0d -> count=%0d", n, count);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
